// File: rtl/mtr_pkg.sv
// Shared types, widths and ramp arithmetic for the motor duty ramp stage.
package mtr_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DECEL = 2'd1,
    DEAD  = 2'd2
  } ramp_state_t;

  localparam int MAG_W = 10;
  localparam int CMD_W = 11;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  localparam logic [MAG_W-1:0] MAG_MAX = 10'h3FF;

  // One slew step from cur toward tgt; 11-bit intermediates so neither
  // direction wraps, and the result never passes tgt.
  function automatic logic [MAG_W-1:0] ramp_toward(input logic [MAG_W-1:0] cur,
                                                   input logic [MAG_W-1:0] tgt,
                                                   input logic [MAG_W-1:0] step);
    logic [MAG_W:0] up;
    logic [MAG_W:0] dn;
    up = {1'b0, cur} + {1'b0, step};
    dn = {1'b0, cur} - {1'b0, step};
    ramp_toward = cur;
    if (cur < tgt) begin
      ramp_toward = (up > {1'b0, tgt}) ? tgt : up[MAG_W-1:0];
    end else if (cur > tgt) begin
      ramp_toward = (dn[MAG_W] || (dn < {1'b0, tgt})) ? tgt : dn[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running wrap counter kept in lockstep with the PWM period counter;
// tick is high for the single all-ones cycle that ends each period.
module period_tick_gen #(
  parameter int W = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == {W{1'b1}});

endmodule

// File: rtl/mtr_duty_ramp.sv
// Slew-limited duty magnitude and direction for the PWM stage, updated only at
// period boundaries. Define MTR_DUTY_RAMP_BRAKE_EN to add the brake output.
module mtr_duty_ramp
  import mtr_pkg::*;
#(
  parameter int STEP         = 16,
  parameter int DEAD_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] spd_cmd,
  input  logic             cmd_vld,
  output logic [MAG_W-1:0] duty,
  output logic             dir,
  output logic             at_tgt,
  output logic             busy_rev
`ifdef MTR_DUTY_RAMP_BRAKE_EN
  ,
  output logic             brake
`endif
);

  localparam logic [MAG_W-1:0] STEP_V    = MAG_W'(STEP);
  localparam logic [3:0]       DEAD_LAST = 4'(DEAD_PERIODS - 1);
  localparam logic [CMD_W-1:0] CMD_MIN   = {1'b1, {(CMD_W-1){1'b0}}};

  ramp_state_t      state;
  logic [3:0]       dead_cnt;
  logic [MAG_W-1:0] tgt_mag;
  logic             tgt_dir;
  logic [MAG_W-1:0] cmd_mag;
  logic [MAG_W-1:0] cmd_neg;
  logic             cmd_dir;
  logic             tick;
  logic             mismatch;
  logic [MAG_W-1:0] run_duty;
  logic [MAG_W-1:0] down_duty;

  period_tick_gen #(.W(MAG_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // cmd_vld is a one-cycle strobe with no back-pressure: spd_cmd is taken on
  // every cycle it is high, so the last strobe before a tick wins.
  assign cmd_neg = MAG_W'(0) - spd_cmd[MAG_W-1:0];

  always_comb begin
    cmd_mag = spd_cmd[MAG_W-1:0];
    if (spd_cmd == CMD_MIN) begin
      cmd_mag = MAG_MAX;
    end else if (spd_cmd[CMD_W-1]) begin
      cmd_mag = cmd_neg;
    end
    cmd_dir = spd_cmd[CMD_W-1] ? DIR_REV : DIR_FWD;
    if (spd_cmd == '0) begin
      cmd_dir = dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_mag <= '0;
      tgt_dir <= DIR_FWD;
    end else if (cmd_vld) begin
      tgt_mag <= cmd_mag;
      tgt_dir <= cmd_dir;
    end
  end

  // A zero target never asks for a flip, whatever direction it carries.
  assign mismatch  = (tgt_dir != dir) && (tgt_mag != '0);
  assign run_duty  = ramp_toward(duty, tgt_mag, STEP_V);
  assign down_duty = ramp_toward(duty, '0, STEP_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      duty     <= '0;
      dir      <= DIR_FWD;
      dead_cnt <= '0;
`ifdef MTR_DUTY_RAMP_BRAKE_EN
      brake    <= 1'b0;
`endif
    end else if (tick) begin
      case (state)
        RUN: begin
          if (!mismatch) begin
            duty <= run_duty;
          end else if (duty != '0) begin
            duty  <= down_duty;
            state <= DECEL;
          end else begin
            dead_cnt <= '0;
            state    <= DEAD;
`ifdef MTR_DUTY_RAMP_BRAKE_EN
            brake    <= 1'b1;
`endif
          end
        end
        DECEL: begin
          if (!mismatch) begin
            duty  <= run_duty;
            state <= RUN;
          end else begin
            duty <= down_duty;
            if (down_duty == '0) begin
              dead_cnt <= '0;
              state    <= DEAD;
`ifdef MTR_DUTY_RAMP_BRAKE_EN
              brake    <= 1'b1;
`endif
            end
          end
        end
        DEAD: begin
          duty <= '0;
          if (!mismatch || (dead_cnt == DEAD_LAST)) begin
            if (mismatch) begin
              dir <= tgt_dir;
            end
            dead_cnt <= '0;
            state    <= RUN;
`ifdef MTR_DUTY_RAMP_BRAKE_EN
            brake    <= 1'b0;
`endif
          end else begin
            dead_cnt <= dead_cnt + 4'd1;
          end
        end
        default: begin
          state <= RUN;
`ifdef MTR_DUTY_RAMP_BRAKE_EN
          brake <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign at_tgt   = (state == RUN) && (duty == tgt_mag) &&
                    ((dir == tgt_dir) || (tgt_mag == '0));
  assign busy_rev = (state != RUN);

endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Directed bench for mtr_duty_ramp: a default-parameter instance and a fast
// instance (STEP=100, DEAD_PERIODS=1) for saturation and async reset.
module tb_mtr_duty_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b0;
  logic [10:0] spd_cmd   = '0;
  logic        cmd_vld   = 1'b0;
  logic [10:0] spd_cmd_b = '0;
  logic        cmd_vld_b = 1'b0;
  logic [9:0]  duty, duty_b;
  logic        dir, dir_b, at_tgt, at_tgt_b, busy_rev, busy_rev_b;
`ifdef MTR_DUTY_RAMP_BRAKE_EN
  logic        brake, brake_b;
`endif

  int checks   = 0;
  int failures = 0;

  mtr_duty_ramp #(.STEP(16), .DEAD_PERIODS(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spd_cmd  (spd_cmd),
    .cmd_vld  (cmd_vld),
    .duty     (duty),
    .dir      (dir),
    .at_tgt   (at_tgt),
    .busy_rev (busy_rev)
`ifdef MTR_DUTY_RAMP_BRAKE_EN
    ,
    .brake    (brake)
`endif
  );

  mtr_duty_ramp #(.STEP(100), .DEAD_PERIODS(1)) u_big (
    .clk      (clk),
    .rst_n    (rst_n),
    .spd_cmd  (spd_cmd_b),
    .cmd_vld  (cmd_vld_b),
    .duty     (duty_b),
    .dir      (dir_b),
    .at_tgt   (at_tgt_b),
    .busy_rev (busy_rev_b)
`ifdef MTR_DUTY_RAMP_BRAKE_EN
    ,
    .brake    (brake_b)
`endif
  );

  // Bench-side period counter, reset exactly like the PWM period counter.
  logic [9:0] tb_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 10'd1;
  end

  // Duty/dir may only move on the edge that ends a cnt==3FF cycle.
  logic       mon_ok = 1'b0;
  logic [9:0] mon_duty, mon_duty_b;
  logic       mon_dir, mon_dir_b;
  always @(negedge clk) begin
    if (rst_n && mon_ok && (tb_cnt != 10'd0)) begin
      checks++;
      if ({duty, dir} !== {mon_duty, mon_dir}) begin
        failures++;
        $display("FAIL hold_main t=%0t got duty=%0d dir=%0b exp duty=%0d dir=%0b",
                 $time, duty, dir, mon_duty, mon_dir);
      end
      checks++;
      if ({duty_b, dir_b} !== {mon_duty_b, mon_dir_b}) begin
        failures++;
        $display("FAIL hold_big t=%0t got duty=%0d dir=%0b exp duty=%0d dir=%0b",
                 $time, duty_b, dir_b, mon_duty_b, mon_dir_b);
      end
    end
    mon_duty   = duty;
    mon_dir    = dir;
    mon_duty_b = duty_b;
    mon_dir_b  = dir_b;
    mon_ok     = rst_n;
  end

  task automatic wait_tick();
    do @(negedge clk); while (tb_cnt != 10'h3FF);
    @(posedge clk);
    #1;
  endtask

  task automatic send_main(input logic [10:0] v);
    @(negedge clk);
    spd_cmd = v;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic send_big(input logic [10:0] v);
    @(negedge clk);
    spd_cmd_b = v;
    cmd_vld_b = 1'b1;
    @(negedge clk);
    cmd_vld_b = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({duty, dir, at_tgt, busy_rev} !== {10'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_main duty=%0d dir=%0b at=%0b busy=%0b exp 0/1/1/0",
               duty, dir, at_tgt, busy_rev);
    end
    checks++;
    if ({duty_b, dir_b, at_tgt_b, busy_rev_b} !== {10'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_big duty=%0d dir=%0b at=%0b busy=%0b exp 0/1/1/0",
               duty_b, dir_b, at_tgt_b, busy_rev_b);
    end
`ifdef MTR_DUTY_RAMP_BRAKE_EN
    checks++;
    if (brake !== 1'b0) begin
      failures++;
      $display("FAIL reset_brake got=%0b exp=0", brake);
    end
`endif
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({duty, dir, at_tgt, busy_rev} !== {10'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL post_reset duty=%0d dir=%0b at=%0b busy=%0b exp 0/1/1/0",
               duty, dir, at_tgt, busy_rev);
    end
  endtask

  task automatic test_ramp_up();
    logic [9:0] exp_up[7] = '{10'd16, 10'd32, 10'd48, 10'd64, 10'd80, 10'd96, 10'd100};
    send_main(11'd100);
    checks++;
    if ({duty, at_tgt} !== {10'd0, 1'b0}) begin
      failures++;
      $display("FAIL up_capture duty=%0d at=%0b exp 0/0", duty, at_tgt);
    end
    for (int i = 0; i < 7; i++) begin
      wait_tick();
      checks++;
      if ({duty, dir, busy_rev, at_tgt} !== {exp_up[i], 1'b1, 1'b0, (i == 6)}) begin
        failures++;
        $display("FAIL up[%0d] duty=%0d dir=%0b busy=%0b at=%0b exp %0d/1/0/%0b",
                 i, duty, dir, busy_rev, at_tgt, exp_up[i], (i == 6));
      end
    end
  endtask

  task automatic test_reverse();
    logic [9:0] exp_dn[7] = '{10'd84, 10'd68, 10'd52, 10'd36, 10'd20, 10'd4, 10'd0};
    logic [9:0] exp_rv[4] = '{10'd16, 10'd32, 10'd48, 10'd50};
    send_main(-11'sd50);
    for (int i = 0; i < 7; i++) begin
      wait_tick();
      checks++;
      if ({duty, dir, busy_rev, at_tgt} !== {exp_dn[i], 1'b1, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL decel[%0d] duty=%0d dir=%0b busy=%0b at=%0b exp %0d/1/1/0",
                 i, duty, dir, busy_rev, at_tgt, exp_dn[i]);
      end
`ifdef MTR_DUTY_RAMP_BRAKE_EN
      checks++;
      if (brake !== (i == 6)) begin
        failures++;
        $display("FAIL decel_brake[%0d] got=%0b exp=%0b", i, brake, (i == 6));
      end
`endif
    end
    for (int j = 0; j < 4; j++) begin
      wait_tick();
      checks++;
      if ({duty, dir, busy_rev} !== {10'd0, (j != 3), (j != 3)}) begin
        failures++;
        $display("FAIL dead[%0d] duty=%0d dir=%0b busy=%0b exp 0/%0b/%0b",
                 j, duty, dir, busy_rev, (j != 3), (j != 3));
      end
`ifdef MTR_DUTY_RAMP_BRAKE_EN
      checks++;
      if (brake !== (j != 3)) begin
        failures++;
        $display("FAIL dead_brake[%0d] got=%0b exp=%0b", j, brake, (j != 3));
      end
`endif
    end
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      checks++;
      if ({duty, dir, busy_rev, at_tgt} !== {exp_rv[k], 1'b0, 1'b0, (k == 3)}) begin
        failures++;
        $display("FAIL rev_up[%0d] duty=%0d dir=%0b busy=%0b at=%0b exp %0d/0/0/%0b",
                 k, duty, dir, busy_rev, at_tgt, exp_rv[k], (k == 3));
      end
    end
  endtask

  task automatic test_non_tick();
    do @(negedge clk); while (tb_cnt != 10'd500);
    spd_cmd = -11'sd64;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    checks++;
    if ({duty, at_tgt} !== {10'd50, 1'b0}) begin
      failures++;
      $display("FAIL mid_strobe duty=%0d at=%0b exp 50/0", duty, at_tgt);
    end
    wait_tick();
    checks++;
    if ({duty, dir, at_tgt} !== {10'd64, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_strobe_tick duty=%0d dir=%0b at=%0b exp 64/0/1", duty, dir, at_tgt);
    end
    do @(negedge clk); while (tb_cnt != 10'h3FF);
    spd_cmd = -11'sd80;
    cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({duty, at_tgt} !== {10'd64, 1'b0}) begin
      failures++;
      $display("FAIL tick_strobe duty=%0d at=%0b exp 64/0", duty, at_tgt);
    end
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_tick();
    checks++;
    if ({duty, at_tgt} !== {10'd80, 1'b1}) begin
      failures++;
      $display("FAIL tick_strobe_next duty=%0d at=%0b exp 80/1", duty, at_tgt);
    end
  endtask

  task automatic test_dead_revert();
    pulse_reset();
    checks++;
    if ({duty, dir, busy_rev} !== {10'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL revert_reset duty=%0d dir=%0b busy=%0b exp 0/1/0", duty, dir, busy_rev);
    end
    send_main(-11'sd50);
    for (int i = 0; i < 2; i++) begin
      wait_tick();
      checks++;
      if ({duty, dir, busy_rev, at_tgt} !== {10'd0, 1'b1, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL revert_dead[%0d] duty=%0d dir=%0b busy=%0b at=%0b exp 0/1/1/0",
                 i, duty, dir, busy_rev, at_tgt);
      end
    end
    send_main(11'd30);
    wait_tick();
    checks++;
    if ({duty, dir, busy_rev} !== {10'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL revert_run duty=%0d dir=%0b busy=%0b exp 0/1/0", duty, dir, busy_rev);
    end
`ifdef MTR_DUTY_RAMP_BRAKE_EN
    checks++;
    if (brake !== 1'b0) begin
      failures++;
      $display("FAIL revert_brake got=%0b exp=0", brake);
    end
`endif
    wait_tick();
    checks++;
    if ({duty, dir, at_tgt} !== {10'd16, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL revert_up0 duty=%0d dir=%0b at=%0b exp 16/1/0", duty, dir, at_tgt);
    end
    wait_tick();
    checks++;
    if ({duty, dir, at_tgt} !== {10'd30, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL revert_up1 duty=%0d dir=%0b at=%0b exp 30/1/1", duty, dir, at_tgt);
    end
  endtask

  task automatic test_async_reset();
    send_big(11'd300);
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      checks++;
      if ({duty_b, dir_b, busy_rev_b} !== {10'(100 * i), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL big_up[%0d] duty=%0d dir=%0b busy=%0b exp %0d/1/0",
                 i, duty_b, dir_b, busy_rev_b, 100 * i);
      end
    end
    send_big(-11'sd50);
    wait_tick();
    checks++;
    if ({duty_b, dir_b, busy_rev_b} !== {10'd200, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL big_decel duty=%0d dir=%0b busy=%0b exp 200/1/1", duty_b, dir_b, busy_rev_b);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({duty_b, dir_b, busy_rev_b, at_tgt_b} !== {10'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset duty=%0d dir=%0b busy=%0b at=%0b exp 0/1/0/1",
               duty_b, dir_b, busy_rev_b, at_tgt_b);
    end
    checks++;
    if (duty !== 10'd0) begin
      failures++;
      $display("FAIL async_reset_main duty=%0d exp 0", duty);
    end
`ifdef MTR_DUTY_RAMP_BRAKE_EN
    checks++;
    if (brake_b !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_brake got=%0b exp=0", brake_b);
    end
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    send_big(11'h400);
    wait_tick();
    checks++;
    if ({duty_b, dir_b, busy_rev_b} !== {10'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sat_dead duty=%0d dir=%0b busy=%0b exp 0/1/1", duty_b, dir_b, busy_rev_b);
    end
    wait_tick();
    checks++;
    if ({duty_b, dir_b, busy_rev_b} !== {10'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sat_flip duty=%0d dir=%0b busy=%0b exp 0/0/0", duty_b, dir_b, busy_rev_b);
    end
    for (int k = 1; k <= 12; k++) begin
      wait_tick();
      checks++;
      if ({duty_b, dir_b, at_tgt_b} !== {((k <= 10) ? 10'(100 * k) : 10'd1023), 1'b0, (k > 10)}) begin
        failures++;
        $display("FAIL sat_up[%0d] duty=%0d dir=%0b at=%0b", k, duty_b, dir_b, at_tgt_b);
      end
    end
    send_big(11'd0);
    checks++;
    if ({dir_b, at_tgt_b} !== {1'b0, 1'b0}) begin
      failures++;
      $display("FAIL zero_capture dir=%0b at=%0b exp 0/0", dir_b, at_tgt_b);
    end
    for (int k = 1; k <= 11; k++) begin
      wait_tick();
      checks++;
      if ({duty_b, dir_b, at_tgt_b} !== {((k <= 10) ? 10'(1023 - 100 * k) : 10'd0), 1'b0, (k == 11)}) begin
        failures++;
        $display("FAIL sat_down[%0d] duty=%0d dir=%0b at=%0b", k, duty_b, dir_b, at_tgt_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reverse();
    test_non_tick();
    test_dead_revert();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
